// File: rtl/mc_cpu.sv
// Multi-cycle CPU: FETCH/EXEC/MEM/HALT with a level request/ack data port.
// Build option: define MC_CPU_MUL_EN to add the opcode 24 multiplier.
module mc_cpu #(
  parameter int DATA_W  = 32,
  parameter int REG_N   = 32,
  parameter int ADDR_W  = 8,
  parameter int IADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IADDR_W-1:0] inst_addr,
  input  logic [31:0]        inst_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic               retired,
  output logic               halted
);

  localparam int RW    = $clog2(REG_N);
  localparam int LUI_W = ((DATA_W < 32) ? DATA_W : 32) - 16;

  localparam logic [5:0] OP_LW   = 6'd1;
  localparam logic [5:0] OP_SW   = 6'd2;
  localparam logic [5:0] OP_LLI  = 6'd3;
  localparam logic [5:0] OP_LUI  = 6'd4;
  localparam logic [5:0] OP_SLT  = 6'd5;
  localparam logic [5:0] OP_SEQ  = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;
  localparam logic [5:0] OP_ADD  = 6'd9;
  localparam logic [5:0] OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SUB  = 6'd11;
  localparam logic [5:0] OP_SUBI = 6'd12;
  localparam logic [5:0] OP_SLL  = 6'd13;
  localparam logic [5:0] OP_SRL  = 6'd14;
  localparam logic [5:0] OP_AND  = 6'd15;
  localparam logic [5:0] OP_ANDI = 6'd16;
  localparam logic [5:0] OP_OR   = 6'd17;
  localparam logic [5:0] OP_ORI  = 6'd18;
  localparam logic [5:0] OP_INV  = 6'd19;
  localparam logic [5:0] OP_XOR  = 6'd20;
  localparam logic [5:0] OP_XORI = 6'd21;
  localparam logic [5:0] OP_JMP  = 6'd22;
  localparam logic [5:0] OP_HALT = 6'd23;
`ifdef MC_CPU_MUL_EN
  localparam logic [5:0] OP_MUL  = 6'd24;
`endif

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t             r_state;
  logic [IADDR_W-1:0] r_pc;
  logic [31:0]        r_ir;
  logic [DATA_W-1:0]  r_regs [REG_N];
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_retired;
  logic               r_halted;

  logic [5:0]         w_op;
  logic [RW-1:0]      w_rd;
  logic [RW-1:0]      w_rs;
  logic [RW-1:0]      w_rt;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic [DATA_W-1:0]  w_d;
  logic [DATA_W-1:0]  w_maddr;
  logic [DATA_W-1:0]  w_lui;
  logic               w_sh_big;
  logic               w_wen;
  logic [DATA_W-1:0]  w_val;
  logic [IADDR_W-1:0] w_pcn;
  logic               w_is_mem;

  assign w_op   = r_ir[31:26];
  assign w_rd   = r_ir[21 +: RW];
  assign w_rs   = r_ir[16 +: RW];
  assign w_rt   = r_ir[11 +: RW];
  assign w_imm  = DATA_W'(r_ir[15:0]);
  // R0 is never written and resets to zero, so a plain read returns 0
  assign w_a    = r_regs[w_rs];
  assign w_b    = r_regs[w_rt];
  assign w_d    = r_regs[w_rd];
  assign w_maddr  = w_a + DATA_W'(r_ir[15:11]);
  assign w_sh_big = (w_b >= DATA_W'(DATA_W));
  assign w_is_mem = (w_op == OP_LW) || (w_op == OP_SW);

  if (LUI_W > 0) begin : g_lui
    always_comb begin
      w_lui = w_d;
      w_lui[16 +: LUI_W] = r_ir[LUI_W-1:0];
    end
  end else begin : g_no_lui
    assign w_lui = w_d;
  end

`ifdef MC_CPU_MUL_EN
  logic [DATA_W-1:0] w_mul;
  assign w_mul = w_a * w_b;
`endif

  always_comb begin
    w_wen = 1'b0;
    w_val = w_d;
    w_pcn = r_pc + IADDR_W'(1);
    case (w_op)
      OP_LLI: begin
        w_wen = 1'b1;
        w_val[15:0] = r_ir[15:0];
      end
      OP_LUI: begin
        w_wen = 1'b1;
        w_val = w_lui;
      end
      OP_SLT: begin
        w_wen = 1'b1;
        w_val = DATA_W'(w_a < w_b);
      end
      OP_SEQ: begin
        w_wen = 1'b1;
        w_val = DATA_W'(w_a == w_b);
      end
      OP_BEQ: if (w_d == w_imm) w_pcn = r_pc + IADDR_W'(2);
      OP_BNE: if (w_d != w_imm) w_pcn = r_pc + IADDR_W'(2);
      OP_ADD:  begin w_wen = 1'b1; w_val = w_a + w_b;   end
      OP_ADDI: begin w_wen = 1'b1; w_val = w_a + w_imm; end
      OP_SUB:  begin w_wen = 1'b1; w_val = w_a - w_b;   end
      OP_SUBI: begin w_wen = 1'b1; w_val = w_a - w_imm; end
      OP_SLL: begin
        w_wen = 1'b1;
        w_val = w_sh_big ? '0 : (w_a << w_b);
      end
      OP_SRL: begin
        w_wen = 1'b1;
        w_val = w_sh_big ? '0 : (w_a >> w_b);
      end
      OP_AND:  begin w_wen = 1'b1; w_val = w_a & w_b;   end
      OP_ANDI: begin w_wen = 1'b1; w_val = w_a & w_imm; end
      OP_OR:   begin w_wen = 1'b1; w_val = w_a | w_b;   end
      OP_ORI:  begin w_wen = 1'b1; w_val = w_a | w_imm; end
      OP_INV:  begin w_wen = 1'b1; w_val = ~w_a;        end
      OP_XOR:  begin w_wen = 1'b1; w_val = w_a ^ w_b;   end
      OP_XORI: begin w_wen = 1'b1; w_val = w_a ^ w_imm; end
      OP_JMP:  w_pcn = w_d[IADDR_W-1:0];
`ifdef MC_CPU_MUL_EN
      OP_MUL:  begin w_wen = 1'b1; w_val = w_mul; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_retired   <= 1'b0;
      r_halted    <= 1'b0;
      for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_retired <= 1'b0;
          r_ir      <= inst_data;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_SW);
            r_mem_addr  <= ADDR_W'(w_maddr);
            r_mem_wdata <= w_d;
            r_state     <= S_MEM;
          end else if (w_op == OP_HALT) begin
            r_retired <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            if (w_wen && (w_rd != '0)) r_regs[w_rd] <= w_val;
            r_pc      <= w_pcn;
            r_retired <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_MEM: begin
          // outputs stay frozen for as many wait states as the memory needs
          if (mem_ack) begin
            if (!r_mem_we && (w_rd != '0)) r_regs[w_rd] <= mem_rdata;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_pc      <= r_pc + IADDR_W'(1);
            r_retired <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_HALT: r_retired <= 1'b0;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign inst_addr = r_pc;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign retired   = r_retired;
  assign halted    = r_halted;

endmodule

// File: tb/tb_mc_cpu.sv
// Scoreboard bench for mc_cpu: expected retire PCs and memory
// transactions are queued by stimulus and popped by a monitor.
module tb_mc_cpu;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int IW = 8;

  localparam int LW = 1, SW = 2, LLI = 3, LUI = 4, SLT = 5;
  localparam int BEQ = 7, BNE = 8, ADD = 9, SUB = 11, SLL = 13;
  localparam int XORI = 21, JMP = 22, HALT = 23, MUL = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] inst_addr;
  logic [31:0]   inst_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          retired, halted;

  logic [31:0] rom [256];

  always #5 clk = ~clk;
  assign inst_data = rom[inst_addr];

  mc_cpu #(.DATA_W(DW), .REG_N(32), .ADDR_W(AW), .IADDR_W(IW)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retired(retired), .halted(halted)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            hold;
  } mexp_t;

  mexp_t         mq [$];
  logic [IW-1:0] pq [$];
  int            dq [$];
  logic [DW-1:0] rq [$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ir(int op, int rd, int rs, int rt);
    return {6'(op), 5'(rd), 5'(rs), 5'(rt), 11'd0};
  endfunction

  function automatic logic [31:0] ii(int op, int rd, int rs, int imm);
    return {6'(op), 5'(rd), 5'(rs), 16'(imm)};
  endfunction

  task automatic push_m(logic we, int a, logic [DW-1:0] wd, int d,
                        logic [DW-1:0] rd);
    mexp_t m;
    m.we = we; m.addr = AW'(a); m.wdata = wd; m.hold = d + 1;
    mq.push_back(m);
    dq.push_back(d);
    rq.push_back(rd);
  endtask

  // memory responder: acks after the queued number of wait cycles
  initial begin
    int cnt;
    logic busy;
    logic [DW-1:0] rd;
    mem_ack = 1'b0; mem_rdata = '0; busy = 1'b0; cnt = 0; rd = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_ack = 1'b0; busy = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = (dq.size() > 0) ? dq.pop_front() : 0;
          rd  = (rq.size() > 0) ? rq.pop_front() : '0;
        end
        if (cnt == 0) begin
          mem_ack = 1'b1; mem_rdata = rd; busy = 1'b0;
        end else cnt--;
      end
    end
  end

  // monitor
  initial begin
    logic t_act, t_we, t_stable;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wd;
    int t_cnt;
    mexp_t m;
    logic [IW-1:0] e;
    t_act = 1'b0; t_cnt = 0; t_stable = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) t_act = 1'b0;
      else begin
        if (retired) begin
          if (pq.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL retire: unexpected at pc %0h", inst_addr);
          end else begin
            e = pq.pop_front();
            chk("retire_pc", 64'(inst_addr), 64'(e));
          end
        end
        if (mem_req) begin
          if (!t_act) begin
            t_act = 1'b1; t_cnt = 0; t_stable = 1'b1;
            t_we = mem_we; t_addr = mem_addr; t_wd = mem_wdata;
          end else if ({mem_we, mem_addr, mem_wdata} !== {t_we, t_addr, t_wd})
            t_stable = 1'b0;
          t_cnt++;
          if (mem_ack) begin
            t_act = 1'b0;
            if (mq.size() == 0) begin
              n_vec++; n_bad++;
              $display("FAIL mem: unexpected access addr %0h", t_addr);
            end else begin
              m = mq.pop_front();
              chk("mem_we", 64'(t_we), 64'(m.we));
              chk("mem_addr", 64'(t_addr), 64'(m.addr));
              chk("mem_wdata", 64'(t_wd), 64'(m.wdata));
              chk("mem_hold", 64'(t_cnt), 64'(m.hold));
              chk("mem_stable", 64'(t_stable), 64'd1);
            end
          end
        end
      end
    end
  end

  task automatic reset_start();
    @(posedge clk); #1;
    rst = 1'b1;
    pq.delete(); mq.delete(); dq.delete(); rq.delete();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic reset_end(bit check);
    @(posedge clk); #1;
    if (check) begin
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_pc", 64'(inst_addr), 64'd0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_halt(int lim);
    int k = 0;
    while (!halted && k < lim) begin
      @(posedge clk); #1; k++;
    end
    chk("halt_seen", 64'(halted), 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic wait_drain(string nm, int lim);
    int k = 0;
    while ((pq.size() + mq.size()) != 0 && k < lim) begin
      @(negedge clk); #1; k++;
    end
    chk(nm, 64'(pq.size() + mq.size()), 64'd0);
  endtask

  task automatic wait_req(int lim);
    int k = 0;
    while (!mem_req && k < lim) begin
      @(posedge clk); #1; k++;
    end
    chk("req_seen", 64'(mem_req), 64'd1);
  endtask

  initial begin
    int cnt;
    bit ok;
    logic [DW-1:0] mul_exp;
`ifdef MC_CPU_MUL_EN
    mul_exp = 32'hFFFF_FFFF;
`else
    mul_exp = 32'h0000_1234;
`endif

    // program 1: ALU, memory, BEQ, MUL, shifts
    reset_start();
    rom[0]  = ii(LLI, 1, 0, 5);
    rom[1]  = ii(LLI, 2, 0, 7);
    rom[2]  = ir(ADD, 3, 1, 2);
    rom[3]  = ir(SW, 3, 0, 4);
    rom[4]  = ir(LW, 4, 0, 4);
    rom[5]  = ii(LLI, 0, 0, 9);
    rom[6]  = ir(SW, 4, 0, 0);
    rom[7]  = ir(SW, 0, 1, 1);
    rom[10] = ii(BEQ, 1, 0, 5);
    rom[11] = ir(HALT, 0, 0, 0);
    rom[12] = ir(SUB, 5, 2, 1);
    rom[13] = ir(SW, 5, 0, 8);
    rom[14] = ii(LLI, 6, 0, 'hFFFF);
    rom[15] = ii(LLI, 7, 0, 1);
    rom[16] = ii(LUI, 7, 0, 1);
    rom[17] = ii(LLI, 8, 0, 'h1234);
    rom[18] = ir(MUL, 8, 6, 7);
    rom[19] = ir(SW, 8, 0, 0);
    rom[20] = ir(SLL, 9, 1, 2);
    rom[21] = ir(SW, 9, 0, 1);
    rom[22] = ii(LLI, 10, 0, 32);
    rom[23] = ii(LLI, 11, 0, 'h77);
    rom[24] = ir(SLL, 11, 1, 10);
    rom[25] = ir(SW, 11, 0, 2);
    rom[26] = ir(SLT, 12, 1, 2);
    rom[27] = ii(XORI, 13, 2, 'hF0);
    rom[28] = ir(ADD, 14, 12, 13);
    rom[29] = ir(SW, 14, 0, 3);
    rom[30] = ir(HALT, 0, 0, 0);
    for (int i = 1; i <= 10; i++) pq.push_back(IW'(i));
    pq.push_back(8'd12);
    for (int i = 13; i <= 30; i++) pq.push_back(IW'(i));
    pq.push_back(8'd30);
    push_m(1'b1, 4, 32'd12, 3, '0);
    push_m(1'b0, 4, 32'd0, 0, 32'hA5);
    push_m(1'b1, 0, 32'hA5, 1, '0);
    push_m(1'b1, 6, 32'd0, 0, '0);
    push_m(1'b1, 8, 32'd2, 0, '0);
    push_m(1'b1, 0, mul_exp, 0, '0);
    push_m(1'b1, 1, 32'h280, 0, '0);
    push_m(1'b1, 2, 32'd0, 0, '0);
    push_m(1'b1, 3, 32'hF8, 2, '0);
    reset_end(1'b1);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (retired) cnt++;
    end
    chk("retired_in_6cyc", 64'(cnt), 64'd3);
    wait_halt(600);
    chk("p1_halt_pc", 64'(inst_addr), 64'd30);
    chk("p1_drain", 64'(pq.size() + mq.size()), 64'd0);

    // program 2: BNE not taken at 10, JMP to 7, HALT frozen
    reset_start();
    rom[0]  = ii(LLI, 1, 0, 5);
    rom[1]  = ii(LLI, 2, 0, 7);
    rom[2]  = ii(LLI, 3, 0, 10);
    rom[3]  = ir(JMP, 3, 0, 0);
    rom[7]  = ir(HALT, 0, 0, 0);
    rom[10] = ii(BNE, 1, 0, 5);
    rom[11] = ir(JMP, 2, 0, 0);
    pq.push_back(8'd1); pq.push_back(8'd2); pq.push_back(8'd3);
    pq.push_back(8'd10); pq.push_back(8'd11); pq.push_back(8'd7);
    pq.push_back(8'd7);
    reset_end(1'b1);
    wait_halt(200);
    chk("p2_halt_pc", 64'(inst_addr), 64'd7);
    ok = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (inst_addr !== 8'd7 || halted !== 1'b1) ok = 1'b0;
    end
    chk("halt_frozen_100", 64'(ok), 64'd1);
    chk("p2_drain", 64'(pq.size() + mq.size()), 64'd0);

    // program 3: reset in the middle of a memory wait
    reset_start();
    rom[0] = ir(SW, 3, 0, 1);
    rom[1] = ii(LLI, 3, 0, 3);
    rom[2] = ir(JMP, 0, 0, 0);
    pq.push_back(8'd1); pq.push_back(8'd2); pq.push_back(8'd0);
    push_m(1'b1, 1, 32'd0, 2, '0);
    dq.push_back(1000); rq.push_back('0);
    reset_end(1'b0);
    wait_drain("p3_first_loop", 100);
    wait_req(20);
    chk("pend_wdata", 64'(mem_wdata), 64'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    pq.push_back(8'd1); pq.push_back(8'd2); pq.push_back(8'd0);
    push_m(1'b1, 1, 32'd0, 0, '0);
    dq.push_back(1000); rq.push_back('0);
    @(posedge clk); #1;
    chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mid_pc", 64'(inst_addr), 64'd0);
    rst = 1'b0;
    wait_drain("p3_after_rst", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and data width, at least 16.
REQ-002 SHALL have parameter REG_N, default 32: register count, a power of two from 2 to 32.
REQ-003 SHALL have parameter ADDR_W, default 8: data-memory address width.
REQ-004 SHALL have parameter IADDR_W, default 8: instruction address (PC) width.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port inst_addr, output, IADDR_W: instruction ROM address, equal to PC.
REQ-008 SHALL have port inst_data, input, 32: combinational ROM word for inst_addr.
REQ-009 SHALL have port mem_req, output, 1: data-memory request, level, held until ack.
REQ-010 SHALL have port mem_we, output, 1: 1 = write, 0 = read; valid while mem_req.
REQ-011 SHALL have port mem_addr, output, ADDR_W: R[rs] + rt, truncated to ADDR_W.
REQ-012 SHALL have ports mem_wdata (output) and mem_rdata (input), each DATA_W: write data R[rd] and read data.
REQ-013 SHALL have port mem_ack, input, 1: one-cycle completion; rdata valid in the same cycle.
REQ-014 SHALL have ports retired, output, 1 (one-cycle pulse per completed instruction) and halted, output, 1 (level).

Function
REQ-015 SHALL use FSM states FETCH, EXEC, MEM, HALT; FETCH latches inst_data into IR and goes to EXEC.
REQ-016 SHALL use field layout op[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0]; register indices taken modulo REG_N.
REQ-017 SHALL support opcodes 0-22 with NOP, LW, SW, LLI, LUI, SLT, SEQ, BEQ, BNE, ADD, ADDi, SUB, SUBi, SLL, SRL, AND, ANDi, OR, ORi, INV, XOR, XORi, JMP semantics and numbering unchanged; 23 = HALT.
REQ-018 SHALL complete non-memory instructions in EXEC: 2 cycles per instruction, PC <= PC+1, retired=1, then FETCH.
REQ-019 SHALL, for LW/SW in EXEC, assert mem_req with mem_we/addr/wdata registered, enter MEM, and hold all outputs stable until mem_ack.
REQ-020 SHALL, on mem_ack in MEM, write mem_rdata to R[rd] (LW only), deassert mem_req next cycle, PC+1, pulse retired, go to FETCH; wait states are unbounded.
REQ-021 SHALL zero-extend imm to DATA_W; LLI writes bits [15:0] and LUI writes bits [31:16] of R[rd], other bits kept; LUI with DATA_W < 32 writes bits [DATA_W-1:16] only.
REQ-022 SHALL treat SLT as unsigned with result 0/1, and make SLL/SRL produce 0 when R[rt] >= DATA_W.
REQ-023 SHALL make BEQ/BNE set PC+2 when the condition holds, else PC+1; JMP sets PC = R[rd][IADDR_W-1:0].
REQ-024 SHALL let PC wrap modulo 2^IADDR_W.
REQ-025 SHALL hardwire R0 to zero: writes ignored, reads return 0.
REQ-026 SHALL, on HALT, retire it, enter HALT, set halted=1, and stay there until rst.
REQ-027 SHALL execute undefined opcodes as NOP.

Reset
REQ-028 SHALL, when rst is asserted, set PC=0, all registers=0, state=FETCH, IR=0, and mem_req=mem_we=retired=halted=0 at the next edge.
REQ-029 SHALL give rst priority in every state, including MEM mid-transaction: mem_req drops and the pending access is abandoned.

Configuration
REQ-030 SHALL, with MC_CPU_MUL_EN defined, implement opcode 24 MUL, R[rd] = low DATA_W bits of R[rs]*R[rt], in EXEC with 2-cycle latency.
REQ-031 SHALL, without MC_CPU_MUL_EN, execute opcode 24 as NOP with no multiplier logic.

Verification
REQ-032 SHALL cover: LLI R1,5; LLI R2,7; ADD R3,R1,R2 -> R3=12, 3 retired pulses across 6 cycles.
REQ-033 SHALL cover: SW R3 at R0+4 with ack delayed 3 cycles -> mem_req held 4 cycles, addr=4, wdata=12, we=1, stable throughout.
REQ-034 SHALL cover: LW R4 at 4 with rdata=0xA5 -> R4=0xA5; a following LLI R0,9 leaves R0 reading 0.
REQ-035 SHALL cover: BEQ R1,5 at PC=10 -> next fetch at 12; BNE R1,5 -> next fetch at 11; JMP R2 -> PC=7.
REQ-036 SHALL cover: rst asserted during MEM wait -> mem_req=0 next cycle, PC=0, R3=0; HALT -> halted=1 and PC frozen for 100 cycles.
REQ-037 SHALL cover, with MC_CPU_MUL_EN: MUL of 0xFFFF and 0x10001 with DATA_W=32 -> 0xFFFFFFFF; without the macro -> rd unchanged.
